mips_multicycle_ctrl: RTL and testbench

//  Multicycle control FSM for the MIPS core. Decodes op/funct from the instruction register and drives one

---
 rtl/mips_multicycle_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: one datapath step per state, memory req/ack handshake
// with a wait-cycle watchdog, TRAP on illegal opcodes or memory timeout.
module mips_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT     = 16,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic       instr_done,
    output logic       illegal,
    output logic       timeout,
    output logic [3:0] state
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_REXE    = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEXE = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JREXE   = 4'd12,
        S_TRAP    = 4'd13
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             timeout_q, timeout_d;
    logic             r_legal;
    logic             is_shift;
    logic [2:0]       r_alu;

    // R-type function decode (JR handled separately)
    always_comb begin
        r_legal = 1'b1;
        r_alu   = ALU_ADD;
        case (funct)
            FN_SLL:  r_alu = ALU_SLL;
            FN_SRL:  r_alu = ALU_SRL;
            FN_ADD:  r_alu = ALU_ADD;
            FN_SUB:  r_alu = ALU_SUB;
            FN_AND:  r_alu = ALU_AND;
            FN_OR:   r_alu = ALU_OR;
            FN_SLT:  r_alu = ALU_SLT;
            default: r_legal = 1'b0;
        endcase
    end

    assign is_shift = (funct == FN_SLL) || (funct == FN_SRL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        timeout_d  = timeout_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctrl   = 3'b000;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                case (op)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_R:           state_d = (funct == FN_JR) ? S_JREXE :
                                              (r_legal ? S_REXE : S_TRAP);
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:        state_d = S_ADDIEXE;
                    default:        state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ack) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ack) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_REXE: begin
                alu_src_a = is_shift ? 2'b10 : 2'b01;
                alu_ctrl  = r_alu;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we     = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b01;
                alu_ctrl   = ALU_SUB;
                pc_src     = 2'b01;
                pc_en      = (op == OP_BEQ) ? zero : ~zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEXE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_we     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JREXE: begin
                pc_en      = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
                state_d = HALT_ON_ILLEGAL ? S_TRAP : S_FETCH;
            end
            default: state_d = S_TRAP;
        endcase

        // Watchdog: an ack in the limit cycle still completes the access
        if (mem_req && !mem_ack) begin
            if (wait_q == WAIT_LIMIT) begin
                state_d   = S_TRAP;
                timeout_d = 1'b1;
            end else begin
                wait_d = wait_q + CNT_W'(1);
            end
        end
    end

    assign timeout = timeout_q;
    assign state   = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: halting instance (MEM_TIMEOUT=4) and a
// non-halting instance (MEM_TIMEOUT=16) driven by the same inputs.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ack;

    logic       a_mem_req, a_mem_we, a_i_or_d, a_ir_write, a_pc_en;
    logic [1:0] a_pc_src;
    logic       a_reg_we, a_reg_dst, a_mem_to_reg;
    logic [1:0] a_alu_src_a, a_alu_src_b;
    logic [2:0] a_alu_ctrl;
    logic       a_instr_done, a_illegal, a_timeout;
    logic [3:0] a_state;

    logic       b_mem_req, b_mem_we, b_i_or_d, b_ir_write, b_pc_en;
    logic [1:0] b_pc_src;
    logic       b_reg_we, b_reg_dst, b_mem_to_reg;
    logic [1:0] b_alu_src_a, b_alu_src_b;
    logic [2:0] b_alu_ctrl;
    logic       b_instr_done, b_illegal, b_timeout;
    logic [3:0] b_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(4), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ack(mem_ack),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .i_or_d(a_i_or_d), .ir_write(a_ir_write),
        .pc_en(a_pc_en), .pc_src(a_pc_src), .reg_we(a_reg_we), .reg_dst(a_reg_dst),
        .mem_to_reg(a_mem_to_reg), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
        .alu_ctrl(a_alu_ctrl), .instr_done(a_instr_done), .illegal(a_illegal),
        .timeout(a_timeout), .state(a_state)
    );

    mips_multicycle_ctrl #(.MEM_TIMEOUT(16), .HALT_ON_ILLEGAL(1'b0)) dut_nh (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ack(mem_ack),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .i_or_d(b_i_or_d), .ir_write(b_ir_write),
        .pc_en(b_pc_en), .pc_src(b_pc_src), .reg_we(b_reg_we), .reg_dst(b_reg_dst),
        .mem_to_reg(b_mem_to_reg), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
        .alu_ctrl(b_alu_ctrl), .instr_done(b_instr_done), .illegal(b_illegal),
        .timeout(b_timeout), .state(b_state)
    );

    wire [19:0] a_outs = {a_mem_req, a_mem_we, a_i_or_d, a_ir_write, a_pc_en, a_pc_src,
                          a_reg_we, a_reg_dst, a_mem_to_reg, a_alu_src_a, a_alu_src_b,
                          a_alu_ctrl, a_instr_done, a_illegal, a_timeout};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        op      = 6'h00;
        funct   = 6'h20;
        zero    = 1'b0;
        mem_ack = 1'b1;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_state", 32'(a_state), 32'd0);
            chk("rst_outs", 32'(a_outs), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("idle_state", 32'(a_state), 32'd0);
        chk("idle_outs", 32'(a_outs), 32'd0);
        step();
        chk("fetch_state", 32'(a_state), 32'd1);

        // ADD, immediate ack
        chk("fetch_req", 32'(a_mem_req), 32'd1);
        chk("fetch_irw", 32'(a_ir_write), 32'd1);
        chk("fetch_pcen", 32'(a_pc_en), 32'd1);
        chk("fetch_srcb", 32'(a_alu_src_b), 32'd1);
        chk("fetch_alu", 32'(a_alu_ctrl), 32'd2);
        step();
        chk("add_decode", 32'(a_state), 32'd2);
        chk("decode_srcb", 32'(a_alu_src_b), 32'd3);
        step();
        chk("add_rexe", 32'(a_state), 32'd7);
        chk("add_srca", 32'(a_alu_src_a), 32'd1);
        chk("add_srcb", 32'(a_alu_src_b), 32'd0);
        chk("add_alu", 32'(a_alu_ctrl), 32'd2);
        chk("add_done_early", 32'(a_instr_done), 32'd0);
        step();
        chk("add_aluwb", 32'(a_state), 32'd8);
        chk("add_regwe", 32'(a_reg_we), 32'd1);
        chk("add_regdst", 32'(a_reg_dst), 32'd1);
        chk("add_done", 32'(a_instr_done), 32'd1);
        funct = 6'h00;
        step();
        chk("add_back_fetch", 32'(a_state), 32'd1);

        // SLL (NOP encoding) uses shamt source
        step();
        step();
        chk("sll_rexe", 32'(a_state), 32'd7);
        chk("sll_srca", 32'(a_alu_src_a), 32'd2);
        chk("sll_alu", 32'(a_alu_ctrl), 32'd3);
        op = 6'h23;
        step();
        chk("sll_aluwb", 32'(a_state), 32'd8);
        step();

        // LW with ack delayed two cycles in MEMRD
        chk("lw_fetch", 32'(a_state), 32'd1);
        step();
        chk("lw_decode", 32'(a_state), 32'd2);
        step();
        chk("lw_memadr", 32'(a_state), 32'd3);
        chk("lw_memadr_srca", 32'(a_alu_src_a), 32'd1);
        chk("lw_memadr_srcb", 32'(a_alu_src_b), 32'd2);
        mem_ack = 1'b0;
        step();
        chk("lw_memrd1", 32'(a_state), 32'd4);
        chk("lw_memrd1_req", 32'(a_mem_req), 32'd1);
        chk("lw_memrd1_iord", 32'(a_i_or_d), 32'd1);
        step();
        chk("lw_memrd2", 32'(a_state), 32'd4);
        chk("lw_memrd2_req", 32'(a_mem_req), 32'd1);
        step();
        mem_ack = 1'b1;
        #1;
        chk("lw_memrd3", 32'(a_state), 32'd4);
        chk("lw_memrd3_req", 32'(a_mem_req), 32'd1);
        chk("lw_memrd3_timeout", 32'(a_timeout), 32'd0);
        step();
        chk("lw_memwb", 32'(a_state), 32'd5);
        chk("lw_regwe", 32'(a_reg_we), 32'd1);
        chk("lw_memtoreg", 32'(a_mem_to_reg), 32'd1);
        chk("lw_regdst", 32'(a_reg_dst), 32'd0);
        chk("lw_done", 32'(a_instr_done), 32'd1);
        op = 6'h04;
        zero = 1'b1;
        step();

        // BEQ taken, then Mealy pc_en with zero low
        step();
        step();
        chk("beq_state", 32'(a_state), 32'd9);
        chk("beq_pcen", 32'(a_pc_en), 32'd1);
        chk("beq_pcsrc", 32'(a_pc_src), 32'd1);
        chk("beq_alu", 32'(a_alu_ctrl), 32'd6);
        chk("beq_done", 32'(a_instr_done), 32'd1);
        zero = 1'b0;
        #1;
        chk("beq_nottaken", 32'(a_pc_en), 32'd0);
        op = 6'h05;
        zero = 1'b1;
        step();

        // BNE with zero=1 not taken
        step();
        step();
        chk("bne_state", 32'(a_state), 32'd9);
        chk("bne_pcen", 32'(a_pc_en), 32'd0);
        op = 6'h00;
        funct = 6'h08;
        step();

        // JR
        step();
        step();
        chk("jr_state", 32'(a_state), 32'd12);
        chk("jr_pcsrc", 32'(a_pc_src), 32'd2);
        chk("jr_pcen", 32'(a_pc_en), 32'd1);
        op = 6'h2B;
        step();

        // SW, immediate ack
        step();
        step();
        step();
        chk("sw_state", 32'(a_state), 32'd6);
        chk("sw_we", 32'(a_mem_we), 32'd1);
        chk("sw_iord", 32'(a_i_or_d), 32'd1);
        chk("sw_done", 32'(a_instr_done), 32'd1);
        op = 6'h08;
        step();
        chk("sw_back_fetch", 32'(a_state), 32'd1);

        // ADDI
        step();
        step();
        chk("addi_exe", 32'(a_state), 32'd10);
        chk("addi_srcb", 32'(a_alu_src_b), 32'd2);
        step();
        chk("addi_wb", 32'(a_state), 32'd11);
        chk("addi_regwe", 32'(a_reg_we), 32'd1);
        chk("addi_regdst", 32'(a_reg_dst), 32'd0);
        op = 6'h3F;
        step();

        // Illegal opcode: sticky trap vs one-cycle trap
        step();
        step();
        chk("ill_trap", 32'(a_state), 32'd13);
        chk("ill_flag", 32'(a_illegal), 32'd1);
        chk("ill_noreq", 32'(a_mem_req), 32'd0);
        chk("ill_nh_trap", 32'(b_state), 32'd13);
        step();
        chk("ill_nh_fetch", 32'(b_state), 32'd1);
        chk("ill_nh_flag", 32'(b_illegal), 32'd0);
        for (int i = 0; i < 9; i++) begin
            chk("ill_held", 32'({a_state, a_illegal}), 32'({4'd13, 1'b1}));
            step();
        end

        // Asynchronous reset from TRAP, then watchdog with ack stuck low
        rst_n = 1'b0;
        mem_ack = 1'b0;
        op = 6'h00;
        funct = 6'h20;
        #1;
        chk("async_rst_state", 32'(a_state), 32'd0);
        chk("async_rst_outs", 32'(a_outs), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("wd_wait", 32'({a_state, a_mem_req}), 32'({4'd1, 1'b1}));
            step();
        end
        chk("wd_trap", 32'(a_state), 32'd13);
        chk("wd_timeout", 32'(a_timeout), 32'd1);
        chk("wd_illegal", 32'(a_illegal), 32'd1);
        step();
        step();
        chk("wd_sticky", 32'(a_timeout), 32'd1);
        chk("wd_nh_waiting", 32'(b_state), 32'd1);
        chk("wd_nh_notimeout", 32'(b_timeout), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("wd_cleared", 32'(a_timeout), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Ack arriving in the limit cycle wins over the watchdog
        for (int i = 0; i < 3; i++) step();
        mem_ack = 1'b1;
        #1;
        chk("limit_state", 32'(a_state), 32'd1);
        step();
        chk("limit_decode", 32'(a_state), 32'd2);
        chk("limit_timeout", 32'(a_timeout), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
